// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Parametrised integer register file with a per-register pending-write
// scoreboard. The issue stage marks a destination busy when it issues the
// producer, and the writeback port clears that mark. RAW and WAW stalls then
// reduce to reading a busy bit.
//
// Parameters
//   XLEN      data width of every register
//   NREGS     number of architectural registers (power of two, >= 2)
//   ZERO_REG  1: register 0 reads 0, ignores writes and is never busy
//   BYPASS    1: a same-cycle writeback is forwarded to the read ports
//   AW, CW    derived address width and busy-count width
//
// Ports
//   i_clk          rising-edge clock
//   i_reset        asynchronous, active-high reset
//   i_rs1_addr     read port 1 address
//   i_rs2_addr     read port 2 address
//   o_rs1_data     read port 1 data (combinational)
//   o_rs2_data     read port 2 data (combinational)
//   o_rs1_busy     read port 1 register pending (combinational)
//   o_rs2_busy     read port 2 register pending (combinational)
//   i_rd_addr      writeback address
//   i_rd_data      writeback data
//   i_rd_wren      writeback strobe: stores data and clears the busy bit
//   i_alloc_valid  request to mark i_alloc_addr pending
//   i_alloc_addr   destination being allocated
//   o_alloc_ready  allocation accepted this cycle (combinational)
//   i_flush        synchronous clear of every busy bit
//   o_busy_count   registered number of busy registers
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(NREGS),
    localparam int unsigned CW      = $clog2(NREGS + 1)
) (
    input  logic            i_clk,
    input  logic            i_reset,

    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,

    input  logic [AW-1:0]   i_rd_addr,
    input  logic [XLEN-1:0] i_rd_data,
    input  logic            i_rd_wren,

    input  logic            i_alloc_valid,
    input  logic [AW-1:0]   i_alloc_addr,
    output logic            o_alloc_ready,

    input  logic            i_flush,
    output logic [CW-1:0]   o_busy_count
);

    // Per-entry storage outputs, gathered for the read multiplexers.
    logic [XLEN-1:0] mem_q [NREGS];
    logic [NREGS-1:0] busy_vec;

    logic            alloc_fire;
    logic            alloc_is_zero;
    logic            alloc_sets;
    logic            wb_clears;
    logic [CW-1:0]   busy_count;
    logic [CW-1:0]   count_next;

    // -------------------------------------------------------------------------
    // Allocation handshake
    // -------------------------------------------------------------------------
    // A busy destination can still be allocated in the cycle its pending
    // writeback lands, so back-to-back producers to the same register do not
    // lose a cycle.
    assign o_alloc_ready = !i_flush &&
                           (!busy_vec[i_alloc_addr] ||
                            (i_rd_wren && (i_rd_addr == i_alloc_addr)));

    assign alloc_fire    = i_alloc_valid && o_alloc_ready;
    assign alloc_is_zero = (ZERO_REG != 0) && (i_alloc_addr == '0);

    // -------------------------------------------------------------------------
    // Storage entries
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < int'(NREGS); i++) begin : g_entry
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            // Hard-wired zero: no flops, never pending.
            assign mem_q[i]    = '0;
            assign busy_vec[i] = 1'b0;
        end else begin : g_reg
            logic [XLEN-1:0] data_q;
            logic            busy_q;
            logic            wr_hit;
            logic            al_hit;

            assign wr_hit = i_rd_wren  && (i_rd_addr    == AW'(i));
            assign al_hit = alloc_fire && (i_alloc_addr == AW'(i));

            // NOTE: the data array is reset along with the busy bits because
            // reads after reset must return 0; a plain RAM macro cannot do this.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    data_q <= '0;
                    busy_q <= 1'b0;
                end else begin
                    // NOTE: non-blocking assignments keep every flop sampling
                    // pre-edge values regardless of statement order.
                    if (wr_hit) begin
                        data_q <= i_rd_data;
                    end

                    // Busy priority: flush, then allocate, then writeback.
                    if (i_flush) begin
                        busy_q <= 1'b0;
                    end else if (al_hit) begin
                        busy_q <= 1'b1;
                    end else if (wr_hit) begin
                        busy_q <= 1'b0;
                    end
                end
            end

            assign mem_q[i]    = data_q;
            assign busy_vec[i] = busy_q;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    logic rs1_fwd;
    logic rs2_fwd;

    // Forwarding never applies to the hard-wired zero register.
    assign rs1_fwd = (BYPASS != 0) && i_rd_wren && (i_rd_addr == i_rs1_addr) &&
                     !((ZERO_REG != 0) && (i_rs1_addr == '0));
    assign rs2_fwd = (BYPASS != 0) && i_rd_wren && (i_rd_addr == i_rs2_addr) &&
                     !((ZERO_REG != 0) && (i_rs2_addr == '0));

    assign o_rs1_data = rs1_fwd ? i_rd_data : mem_q[i_rs1_addr];
    assign o_rs2_data = rs2_fwd ? i_rd_data : mem_q[i_rs2_addr];
    assign o_rs1_busy = rs1_fwd ? 1'b0 : busy_vec[i_rs1_addr];
    assign o_rs2_busy = rs2_fwd ? 1'b0 : busy_vec[i_rs2_addr];

    // -------------------------------------------------------------------------
    // Busy counter
    // -------------------------------------------------------------------------
    // +1 only when an allocation turns a clear bit into a set one; an
    // allocation that lands on a register whose writeback arrives the same
    // cycle leaves the bit set and the count unchanged.
    assign alloc_sets = alloc_fire && !alloc_is_zero && !busy_vec[i_alloc_addr];

    // -1 only when a writeback actually clears a set bit.
    assign wb_clears  = i_rd_wren && busy_vec[i_rd_addr] &&
                        !(alloc_fire && (i_alloc_addr == i_rd_addr));

    // NOTE: count_next gets its default first so no path through this block
    // leaves it unassigned and infers a latch.
    always_comb begin
        count_next = busy_count;
        if (i_flush) begin
            count_next = '0;
        end else begin
            unique case ({alloc_sets, wb_clears})
                2'b10:   count_next = busy_count + CW'(1);
                2'b01:   count_next = busy_count - CW'(1);
                default: count_next = busy_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            busy_count <= '0;
        end else begin
            busy_count <= count_next;
        end
    end

    assign o_busy_count = busy_count;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    // The incremental counter must always match the busy vector it summarises.
    a_count_matches : assert property (
        @(posedge i_clk) disable iff (i_reset)
        32'(busy_count) == $countones(busy_vec)
    );
`endif

endmodule
